mem_ctrl_arbiter: RTL
=====================

// Module: mem_ctrl_arbiter
// PURPOSE
//  Memory controller sharing the single byte-wide RAM port between the ICache miss path and the
//  MEM stage. Sequences multi-byte little-endian reads and writes one byte per cycle. Arbitrates
//  with fixed priority MEM > ICache, never preempts a transfer, and aborts ICache fetches on a
//  PC jump. Sits between ICache/MEM and the top-level RAM/IO bus.
// PARAMETERS
//  ADDR_W   18  RAM address width
//  ICW      4   bytes per ICache fetch (fixed instruction width)
// PORTS
//  clk_in          in   1   clock, all state on posedge
//  rst_in          in   1   reset, synchronous, active-low (0 = reset)
//  rdy_in          in   1   global ready; 0 freezes every register
//  pc_jump_in      in   1   branch/jump redirect; aborts an in-flight ICache fetch
//  ic_req_in       in   1   ICache fetch request, held until ic_done_out or jump
//  ic_addr_in      in   18  ICache fetch byte address
//  ic_done_out     out  1   one-cycle pulse: ic_inst_out valid
//  ic_inst_out     out  32  fetched instruction
//  ic_busy_out     out  1   controller is serving ICache
//  mem_req_in      in   1   MEM request, held until mem_done_out
//  mem_we_in       in   1   1 = store, 0 = load
//  mem_size_in     in   2   00 byte, 01 half, 10/11 word (N = 1/2/4)
//  mem_addr_in     in   32  byte address; bits [17:0] used
//  mem_wdata_in    in   32  store data, byte i = bits [8i+7:8i]
//  mem_done_out    out  1   one-cycle pulse: access complete, mem_rdata_out valid for loads
//  mem_rdata_out   out  32  load data, zero-extended above N bytes
//  mem_busy_out    out  1   controller is serving MEM
//  ram_a_out       out  18  RAM byte address
//  ram_dout_out    out  8   RAM write data
//  ram_wr_out      out  1   1 = write ram_dout_out to ram_a_out this cycle
//  ram_din_in      in   8   RAM read data; 1-cycle latency after ram_a_out
// BEHAVIOUR
//  - Reset (rst_in=0 at an edge): state IDLE; all outputs 0; applies mid-transfer; ram_wr_out
//    is 0 in the cycle after that edge; the partial transfer is discarded.
//  - rdy_in=0: state, counters, and outputs hold; takes precedence over everything but reset.
//  - States: IDLE, READ, WRITE, DONE. Owner register {IC, MEM}; byte counter 0..N.
//  - IDLE, edge t: if mem_req_in, accept MEM (READ or WRITE by mem_we_in, N from mem_size_in),
//    else if ic_req_in && !pc_jump_in, accept IC (READ, N=ICW), else stay. Owner's busy=1 from t.
//  - READ: ram_a_out = A+i, ram_wr_out=0 in cycle t+1+i (i<N); byte i sampled from ram_din_in at
//    edge t+2+i. At edge t+1+N: data register complete, done pulse (owner), busy=0, state DONE.
//    The done pulse is high in cycle t+2+N; data holds until the next accepted read by that owner.
//  - WRITE: ram_a_out=A+i, ram_dout_out=wdata byte i, ram_wr_out=1 in cycle t+1+i; at edge t+N:
//    ram_wr_out=0, mem_done_out pulse, state DONE. Store latency N+1 cycles; load N+2 to done.
//  - Address increment is modulo 2^18 (0x3FFFF wraps to 0x00000).
//  - DONE: lasts one cycle, ignores all requests (requesters drop req on their registered view
//    of done), then IDLE. Back-to-back transfers are therefore separated by exactly one cycle.
//  - pc_jump_in=1 at any edge while owner=IC: abort to IDLE (not DONE), busy=0, no ic_done
//    pulse, even at the completing edge. Ignored while owner=MEM.
//  - mem_req_in and ic_req_in both high in IDLE: MEM wins; IC stays pending, served next.
//  - Requests arriving mid-transfer wait; no preemption, no queue beyond the held req lines.
// TESTING
//  1 IC fetch 0x00100, RAM holds 13 05 00 00 -> ram_a 0x100..0x103, ic_done 6 cycles after
//    accept edge t (cycle t+6), ic_inst_out=0x00000513.
//  2 MEM store word 0x1000, wdata 0xDEADBEEF -> ram_wr writes EF,BE,AD,DE at 0x1000..0x1003 in
//    cycles t+1..t+4; mem_done in cycle t+5.
//  3 MEM load byte 0x2003 (RAM=0x80) -> mem_rdata_out=0x00000080; done in cycle t+3.
//  4 IC and MEM req same edge -> MEM served first, DONE gap of 1, then IC fetched; both correct.
//  5 pc_jump_in at cycle t+3 of IC fetch -> no ic_done; IDLE next cycle; new IC addr accepted.
//  6 rst_in=0 during store byte 1 -> ram_wr_out=0 next cycle, outputs 0; rdy_in=0 for 3 cycles
//    mid-load -> completion delayed by exactly 3 cycles with correct data; halfword at 0x3FFFF
//    reads 0x3FFFF and 0x00000.

Source files
------------

// File: rtl/mem_ctrl_arbiter_if.sv
// rtl/mem_ctrl_arbiter_if.sv - bus bundle between the RAM-port arbiter, its two requesters and the RAM
//
// Purpose: groups the ICache-side, MEM-side and RAM-side signals of mem_ctrl_arbiter.
// Ports (signals):
//   ICache : pc_jump_in, ic_req_in, ic_addr_in -> ic_done_out, ic_inst_out, ic_busy_out
//   MEM    : mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in
//            -> mem_done_out, mem_rdata_out, mem_busy_out
//   RAM    : ram_a_out, ram_dout_out, ram_wr_out <- ram_din_in
// Modports: slave = the controller, master = the requesters/RAM side.
interface mem_ctrl_arbiter_if #(
    parameter int ADDR_W = 18
);
    logic              pc_jump_in;
    logic              ic_req_in;
    logic [ADDR_W-1:0] ic_addr_in;
    logic              ic_done_out;
    logic [31:0]       ic_inst_out;
    logic              ic_busy_out;

    logic              mem_req_in;
    logic              mem_we_in;
    logic [1:0]        mem_size_in;
    logic [31:0]       mem_addr_in;
    logic [31:0]       mem_wdata_in;
    logic              mem_done_out;
    logic [31:0]       mem_rdata_out;
    logic              mem_busy_out;

    logic [ADDR_W-1:0] ram_a_out;
    logic [7:0]        ram_dout_out;
    logic              ram_wr_out;
    logic [7:0]        ram_din_in;

    modport slave (
        input  pc_jump_in, ic_req_in, ic_addr_in,
        input  mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
        input  ram_din_in,
        output ic_done_out, ic_inst_out, ic_busy_out,
        output mem_done_out, mem_rdata_out, mem_busy_out,
        output ram_a_out, ram_dout_out, ram_wr_out
    );

    modport master (
        output pc_jump_in, ic_req_in, ic_addr_in,
        output mem_req_in, mem_we_in, mem_size_in, mem_addr_in, mem_wdata_in,
        output ram_din_in,
        input  ic_done_out, ic_inst_out, ic_busy_out,
        input  mem_done_out, mem_rdata_out, mem_busy_out,
        input  ram_a_out, ram_dout_out, ram_wr_out
    );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// rtl/mem_ctrl_arbiter.sv - byte-wide RAM port arbiter/sequencer for ICache fetches and MEM accesses
//
// Purpose: shares one byte-wide, 1-cycle-latency RAM port between the ICache miss path and the
//   MEM stage. Fixed priority MEM > ICache, no preemption, ICache fetches abort on pc_jump_in.
//   Multi-byte accesses are little-endian, one byte per cycle, address wrapping modulo 2^ADDR_W.
// Ports:
//   clk_in  - clock, all state on posedge
//   rst_in  - synchronous active-low reset
//   rdy_in  - global ready; 0 freezes every register
//   bus     - mem_ctrl_arbiter_if.slave (ICache, MEM and RAM sides)
module mem_ctrl_arbiter #(
    parameter int ADDR_W = 18,
    parameter int ICW    = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_ctrl_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic       {OWN_IC, OWN_MEM}         owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ic_inst_q, ic_inst_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              ic_done_q, ic_done_d;
    logic              mem_done_q, mem_done_d;

    logic [1:0]        byte_idx;
    logic [31:0]       cap_mask;
    logic [31:0]       cap_bits;
    logic [31:0]       wdata_shift;
    logic [2:0]        mem_n;

    // Only the low ADDR_W bits of the MEM address reach the RAM.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr_in[31:ADDR_W];

    always_comb begin
        case (bus.mem_size_in)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        a_d         = a_q;
        wdata_d     = wdata_q;
        ic_inst_d   = ic_inst_q;
        mem_rdata_d = mem_rdata_q;
        ic_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        // RAM data lags the address by one cycle, so the byte arriving now
        // belongs to the address issued when the counter was one lower.
        byte_idx = 2'(cnt_q - 3'd1);
        cap_mask = 32'h0000_00FF << {byte_idx, 3'b000};
        cap_bits = {24'h0, bus.ram_din_in} << {byte_idx, 3'b000};

        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (bus.mem_req_in) begin
                    owner_d = OWN_MEM;
                    state_d = bus.mem_we_in ? WRITE : READ;
                    n_d     = mem_n;
                    a_d     = bus.mem_addr_in[ADDR_W-1:0];
                    wdata_d = bus.mem_wdata_in;
                    if (!bus.mem_we_in) begin
                        mem_rdata_d = '0;
                    end
                end else if (bus.ic_req_in && !bus.pc_jump_in) begin
                    owner_d   = OWN_IC;
                    state_d   = READ;
                    n_d       = 3'(ICW);
                    a_d       = bus.ic_addr_in;
                    ic_inst_d = '0;
                end
            end

            READ: begin
                // A redirect kills the fetch even on its completing edge.
                if (owner_q == OWN_IC && bus.pc_jump_in) begin
                    state_d = IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        if (owner_q == OWN_IC) begin
                            ic_inst_d = (ic_inst_q & ~cap_mask) | cap_bits;
                        end else begin
                            mem_rdata_d = (mem_rdata_q & ~cap_mask) | cap_bits;
                        end
                    end
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        if (owner_q == OWN_IC) begin
                            ic_done_d = 1'b1;
                        end else begin
                            mem_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        a_d   = a_q + ADDR_W'(1);
                    end
                end
            end

            WRITE: begin
                if (cnt_q == n_q - 3'd1) begin
                    state_d    = DONE;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    a_d   = a_q + ADDR_W'(1);
                end
            end

            // One dead cycle lets requesters drop req on their registered view of done.
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IC;
            cnt_q       <= '0;
            n_q         <= '0;
            a_q         <= '0;
            wdata_q     <= '0;
            ic_inst_q   <= '0;
            mem_rdata_q <= '0;
            ic_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            a_q         <= a_d;
            wdata_q     <= wdata_d;
            ic_inst_q   <= ic_inst_d;
            mem_rdata_q <= mem_rdata_d;
            ic_done_q   <= ic_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign wdata_shift = wdata_q >> {cnt_q[1:0], 3'b000};

    assign bus.ram_a_out     = a_q;
    assign bus.ram_wr_out    = (state_q == WRITE);
    assign bus.ram_dout_out  = (state_q == WRITE) ? wdata_shift[7:0] : 8'h00;
    assign bus.ic_done_out   = ic_done_q;
    assign bus.ic_inst_out   = ic_inst_q;
    assign bus.ic_busy_out   = (state_q == READ) && (owner_q == OWN_IC);
    assign bus.mem_done_out  = mem_done_q;
    assign bus.mem_rdata_out = mem_rdata_q;
    assign bus.mem_busy_out  = ((state_q == READ) || (state_q == WRITE)) && (owner_q == OWN_MEM);

endmodule
